alu_sequencer: RTL and testbench

ALU_SEQUENCER -- requirements
Module: alu_sequencer

---
 rtl/alu_sequencer.sv | 133 +++++++++++++
 tb/tb_alu_sequencer.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
// Control sequencer for a single-bus ALU datapath: loads operands, executes, writes back.
// Optional feature macro: ALU_SEQ_ZERO_FLAG_EN adds alu_result input and zero_flag output.
module alu_sequencer (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [2:0] req_op,
  input  logic [1:0] req_src1,
  input  logic [1:0] req_src2,
  input  logic [1:0] req_dst,
  output logic [1:0] bus_sel,
  output logic       en_in1,
  output logic       en_in2,
  output logic [2:0] alu_op,
  output logic       alu_out_en,
  output logic       wr_en,
  output logic [1:0] wr_addr,
  output logic       busy,
  output logic       done
`ifdef ALU_SEQ_ZERO_FLAG_EN
  ,
  input  logic [15:0] alu_result,
  output logic        zero_flag
`endif
);

  localparam int unsigned OP_W  = 3;
  localparam int unsigned IDX_W = 2;
  localparam logic [OP_W-1:0] OP_NOT = OP_W'(2);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD1 = 3'd1,
    LOAD2 = 3'd2,
    EXEC  = 3'd3,
    WRITE = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t           state;
  logic [OP_W-1:0]  op_q;
  logic [IDX_W-1:0] src2_q;
  logic [IDX_W-1:0] dst_q;

  // Outputs are registered: each branch sets the values for the state being entered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      op_q       <= '0;
      src2_q     <= '0;
      dst_q      <= '0;
      req_ready  <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      en_in1     <= 1'b0;
      en_in2     <= 1'b0;
      alu_out_en <= 1'b0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      bus_sel    <= '0;
      alu_op     <= '0;
    end else begin
      req_ready  <= 1'b0;
      busy       <= 1'b1;
      done       <= 1'b0;
      en_in1     <= 1'b0;
      en_in2     <= 1'b0;
      alu_out_en <= 1'b0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      bus_sel    <= '0;
      alu_op     <= op_q;
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            op_q    <= req_op;
            src2_q  <= req_src2;
            dst_q   <= req_dst;
            state   <= LOAD1;
            en_in1  <= 1'b1;
            bus_sel <= req_src1;
            alu_op  <= req_op;
          end else begin
            req_ready <= 1'b1;
            busy      <= 1'b0;
            alu_op    <= '0;
          end
        end
        LOAD1: begin
          // NOT is unary, so the second operand load is skipped.
          if (op_q == OP_NOT) begin
            state <= EXEC;
          end else begin
            state   <= LOAD2;
            en_in2  <= 1'b1;
            bus_sel <= src2_q;
          end
        end
        LOAD2: state <= EXEC;
        EXEC: begin
          state      <= WRITE;
          alu_out_en <= 1'b1;
          wr_en      <= 1'b1;
          wr_addr    <= dst_q;
        end
        WRITE: begin
          state  <= DONE;
          done   <= 1'b1;
          alu_op <= '0;
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
          busy      <= 1'b0;
          alu_op    <= '0;
        end
      endcase
    end
  end

`ifdef ALU_SEQ_ZERO_FLAG_EN
  // Result is valid on the bus while alu_out_en is high, i.e. during WRITE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      zero_flag <= 1'b0;
    end else if (state == WRITE) begin
      zero_flag <= (alu_result == 16'h0000);
    end
  end
`endif

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed self-checking bench for alu_sequencer; define ALU_SEQ_ZERO_FLAG_EN to also cover zero_flag.
module tb_alu_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [2:0] req_op = '0;
  logic [1:0] req_src1 = '0;
  logic [1:0] req_src2 = '0;
  logic [1:0] req_dst = '0;
  logic [1:0] bus_sel;
  logic       en_in1, en_in2;
  logic [2:0] alu_op;
  logic       alu_out_en, wr_en;
  logic [1:0] wr_addr;
  logic       busy, done;
`ifdef ALU_SEQ_ZERO_FLAG_EN
  logic [15:0] alu_result = 16'hFFFF;
  logic        zero_flag;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int prev_t   = 0;

  alu_sequencer dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_src1(req_src1), .req_src2(req_src2), .req_dst(req_dst),
    .bus_sel(bus_sel), .en_in1(en_in1), .en_in2(en_in2), .alu_op(alu_op),
    .alu_out_en(alu_out_en), .wr_en(wr_en), .wr_addr(wr_addr),
    .busy(busy), .done(done)
`ifdef ALU_SEQ_ZERO_FLAG_EN
    , .alu_result(alu_result), .zero_flag(zero_flag)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic [13:0] outs;
  assign outs = {req_ready, busy, done, en_in1, en_in2, alu_out_en, wr_en, wr_addr, bus_sel, alu_op};

  function automatic logic [13:0] mk(input logic rr, input logic bz, input logic dn,
                                     input logic e1, input logic e2, input logic oe,
                                     input logic we, input logic [1:0] wa,
                                     input logic [1:0] bs, input logic [2:0] op);
    return {rr, bz, dn, e1, e2, oe, we, wa, bs, op};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives one request in IDLE and checks every cycle through the return to IDLE.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [1:0] s1,
                        input logic [1:0] s2, input logic [1:0] dst, input logic hold,
                        input int gap, input logic [15:0] res);
    req_valid = 1'b1;
    req_op    = op;
    req_src1  = s1;
    req_src2  = s2;
    req_dst   = dst;
    if (gap != 0) chk({tag, "_gap"}, 32'(cyc - prev_t), 32'(gap));
    prev_t = cyc;
    step();
    req_valid = hold;
    req_op    = ~op;
    req_src1  = ~s1;
    req_src2  = ~s2;
    req_dst   = ~dst;
    chk({tag, "_load1"}, 32'(outs), 32'(mk(0, 1, 0, 1, 0, 0, 0, 2'd0, s1, op)));
    if (op != 3'd2) begin
      step();
      chk({tag, "_load2"}, 32'(outs), 32'(mk(0, 1, 0, 0, 1, 0, 0, 2'd0, s2, op)));
    end
    step();
    chk({tag, "_exec"}, 32'(outs), 32'(mk(0, 1, 0, 0, 0, 0, 0, 2'd0, 2'd0, op)));
    step();
    chk({tag, "_write"}, 32'(outs), 32'(mk(0, 1, 0, 0, 0, 1, 1, dst, 2'd0, op)));
`ifdef ALU_SEQ_ZERO_FLAG_EN
    alu_result = res;
`endif
    step();
    chk({tag, "_done"}, 32'(outs), 32'(mk(0, 1, 1, 0, 0, 0, 0, 2'd0, 2'd0, 3'd0)));
`ifdef ALU_SEQ_ZERO_FLAG_EN
    chk({tag, "_zf"}, 32'(zero_flag), 32'(res == 16'h0000));
    alu_result = 16'hFFFF;
`else
    if (res == 16'hFFFF) $display("note: result %0h", res);
`endif
    step();
    chk({tag, "_idle"}, 32'(outs), 32'(mk(1, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 3'd0)));
  endtask

  initial begin
    // Reset values
    repeat (2) @(posedge clk);
    #1;
    chk("reset", 32'(outs), 32'(mk(1, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 3'd0)));
`ifdef ALU_SEQ_ZERO_FLAG_EN
    chk("reset_zf", 32'(zero_flag), 32'd0);
`endif
    rst = 1'b0;
    step();
    chk("idle0", 32'(outs), 32'(mk(1, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 3'd0)));

    // Individual ops, valid dropped after handshake
    run_op("add", 3'd0, 2'd1, 2'd2, 2'd3, 1'b0, 0, 16'h1234);
    run_op("not", 3'd2, 2'd2, 2'd1, 2'd0, 1'b0, 0, 16'h0001);
    run_op("op7", 3'd7, 2'd3, 2'd1, 2'd2, 1'b0, 0, 16'h0002);
    run_op("sub_z", 3'd1, 2'd0, 2'd3, 2'd1, 1'b0, 0, 16'h0000);
    run_op("add_nz", 3'd0, 2'd2, 2'd3, 2'd2, 1'b0, 0, 16'h0005);

    // Continuous valid, back-to-back ops
    run_op("b2b_and", 3'd3, 2'd1, 2'd3, 2'd0, 1'b1, 0, 16'h00F0);
    run_op("b2b_not", 3'd2, 2'd3, 2'd0, 2'd1, 1'b1, 6, 16'h0000);
    run_op("b2b_xnor", 3'd6, 2'd2, 2'd1, 2'd3, 1'b1, 5, 16'h0007);
    run_op("b2b_or", 3'd4, 2'd0, 2'd2, 2'd2, 1'b1, 6, 16'h0000);
    run_op("b2b_xor", 3'd5, 2'd3, 2'd3, 2'd1, 1'b0, 6, 16'h0101);

    // Reset in EXEC abandons the op
    req_valid = 1'b1;
    req_op    = 3'd1;
    req_src1  = 2'd1;
    req_src2  = 2'd2;
    req_dst   = 2'd3;
    step();
    req_valid = 1'b0;
    step();
    step();
    chk("rst_exec", 32'(outs), 32'(mk(0, 1, 0, 0, 0, 0, 0, 2'd0, 2'd0, 3'd1)));
    #2;
    rst = 1'b1;
    #1;
    chk("rst_async", 32'(outs), 32'(mk(1, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 3'd0)));
    step();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("rst_quiet", 32'(outs), 32'(mk(1, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 3'd0)));
    end
    run_op("post_rst", 3'd0, 2'd3, 2'd2, 2'd1, 1'b0, 0, 16'h0009);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
